sine_lut_scheduler: RTL and testbench

//  Time-multiplexes one registered 1024-entry sine LUT (1-cycle read latency) across NUM_CH NCO channels.

---
 rtl/sine_lut_scheduler_if.sv | 29 ++
 rtl/sine_lut_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_sine_lut_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_lut_scheduler_if.sv
// Signal bundle between the sample-rate timebase / sine LUT side (master)
// and the sine LUT scheduler (slave). The master also returns LUT read data.
interface sine_lut_scheduler_if #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
);
    logic                      sample_tick;
    logic                      phase_sync;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH*PHASE_W-1:0] freq_word;
    logic [ADDR_W-1:0]         lut_addr;
    logic [DATA_W-1:0]         lut_data;
    logic [NUM_CH*DATA_W-1:0]  ch_sample;
    logic                      frame_valid;
    logic                      busy;
    logic                      overrun;

    modport master (
        output sample_tick, phase_sync, ch_en, freq_word, lut_data,
        input  lut_addr, ch_sample, frame_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, phase_sync, ch_en, freq_word, lut_data,
        output lut_addr, ch_sample, frame_valid, busy, overrun
    );
endinterface

// File: rtl/sine_lut_scheduler.sv
// Shares one registered sine LUT (1-cycle read latency) across NUM_CH NCO
// channels. Each accepted sample_tick runs a frame that issues one LUT read
// per channel in order 0..NUM_CH-1, then captures every result into a held
// per-channel sample register and pulses frame_valid.
//
// Frame timeline (tick seen in cycle 0):
//   cycle k+1     : lut_addr shows channel k (loaded at the end of cycle k)
//   cycle k+2     : lut_data for channel k, registered at the end of the cycle
//   cycle NUM_CH+1: DRAIN, last capture
//   cycle NUM_CH+2: IDLE again, frame_valid pulse, a new tick is accepted
module sine_lut_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    sine_lut_scheduler_if.slave bus
);
    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    slot_q, slot_d;
    logic [PHASE_W-1:0] acc_q [NUM_CH];
    logic [PHASE_W-1:0] acc_d [NUM_CH];
    logic [ADDR_W-1:0]  lut_addr_q, lut_addr_d;
    logic               sync_pend_q, sync_pend_d;
    logic               overrun_q, overrun_d;
    logic               frame_valid_q, frame_valid_d;

    // Capture pipeline: stage 1 tracks the channel whose address is on the
    // LUT input, stage 2 the channel whose data is on the LUT output.
    logic               cap1_vld_q, cap1_vld_d;
    logic               cap1_en_q, cap1_en_d;
    logic [CH_W-1:0]    cap1_ch_q, cap1_ch_d;
    logic               cap2_vld_q;
    logic               cap2_en_q;
    logic [CH_W-1:0]    cap2_ch_q;

    logic [DATA_W-1:0]  sample_q [NUM_CH];
    logic [DATA_W-1:0]  sample_d [NUM_CH];

    logic               issue;
    logic [CH_W-1:0]    issue_ch;
    logic               clear_acc;
    logic [PHASE_W-1:0] base;
    logic [PHASE_W-1:0] freq_arr [NUM_CH];

    // Unpack the flat frequency bus into one word per channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            freq_arr[k] = bus.freq_word[k*PHASE_W +: PHASE_W];
        end
    end

    // FSM next-state: frame sequencing, overrun detection, phase_sync handling.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        issue         = 1'b0;
        issue_ch      = '0;
        clear_acc     = 1'b0;
        sync_pend_d   = sync_pend_q;
        overrun_d     = overrun_q;
        frame_valid_d = 1'b0;

        // A tick while a frame is running is dropped and flagged until reset.
        if (state_q != IDLE && bus.sample_tick) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Clearing happens before the issue of channel 0 below, so a
                // simultaneous tick starts the frame from phase zero.
                clear_acc = bus.phase_sync;
                if (bus.sample_tick) begin
                    state_d  = ISSUE;
                    slot_d   = '0;
                    issue    = 1'b1;
                    issue_ch = '0;
                end
            end
            ISSUE: begin
                // Deferred so the running frame still sees its own phases.
                if (bus.phase_sync) begin
                    sync_pend_d = 1'b1;
                end
                if (slot_q == LAST_SLOT) begin
                    state_d = DRAIN;
                end else begin
                    slot_d   = slot_q + 1'b1;
                    issue    = 1'b1;
                    issue_ch = slot_q + 1'b1;
                end
            end
            DRAIN: begin
                clear_acc     = sync_pend_q | bus.phase_sync;
                sync_pend_d   = 1'b0;
                state_d       = IDLE;
                frame_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator update and LUT address for the channel being issued.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = clear_acc ? '0 : acc_q[k];
        end
        lut_addr_d = lut_addr_q;
        base       = clear_acc ? '0 : acc_q[issue_ch];
        cap1_vld_d = issue;
        cap1_ch_d  = issue_ch;
        cap1_en_d  = bus.ch_en[issue_ch];

        if (issue) begin
            if (bus.ch_en[issue_ch]) begin
                // Address comes from the pre-increment phase.
                lut_addr_d       = base[PHASE_W-1 -: ADDR_W];
                acc_d[issue_ch]  = base + freq_arr[issue_ch];
            end else begin
                // Disabled channel still burns its slot but reads address 0.
                lut_addr_d       = '0;
                acc_d[issue_ch]  = '0;
            end
        end
    end

    // Capture the LUT output into the sample register of the stage-2 channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sample_d[k] = sample_q[k];
        end
        if (cap2_vld_q) begin
            sample_d[cap2_ch_q] = cap2_en_q ? bus.lut_data : '0;
        end
    end

    // State, accumulators, capture pipeline and outputs; synchronous reset
    // aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            lut_addr_q    <= '0;
            sync_pend_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            cap1_vld_q    <= 1'b0;
            cap1_en_q     <= 1'b0;
            cap1_ch_q     <= '0;
            cap2_vld_q    <= 1'b0;
            cap2_en_q     <= 1'b0;
            cap2_ch_q     <= '0;
            // NOTE: these register arrays hold architectural state (phases and
            // visible samples), so unlike a RAM they are cleared on reset.
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]    <= '0;
                sample_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            lut_addr_q    <= lut_addr_d;
            sync_pend_q   <= sync_pend_d;
            overrun_q     <= overrun_d;
            frame_valid_q <= frame_valid_d;
            cap1_vld_q    <= cap1_vld_d;
            cap1_en_q     <= cap1_en_d;
            cap1_ch_q     <= cap1_ch_d;
            cap2_vld_q    <= cap1_vld_q;
            cap2_en_q     <= cap1_en_q;
            cap2_ch_q     <= cap1_ch_q;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]    <= acc_d[k];
                sample_q[k] <= sample_d[k];
            end
        end
    end

    // Pack the held samples onto the flat output bus.
    always_comb begin
        bus.ch_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.ch_sample[k*DATA_W +: DATA_W] = sample_q[k];
        end
    end

    assign bus.lut_addr    = lut_addr_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_sine_lut_scheduler.sv
// Self-checking bench for sine_lut_scheduler. A frame-level reference model
// computes each accepted frame's addresses and samples at tick time and
// queues them; a negedge monitor compares whenever the DUT pulses frame_valid
// and also checks busy / overrun / frame_valid timing and sample holding.
module tb_sine_lut_scheduler;
    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;

    typedef struct packed {
        logic [NUM_CH-1:0][ADDR_W-1:0] addr;
        logic [NUM_CH-1:0][DATA_W-1:0] samp;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sine_lut_scheduler_if #(
        .NUM_CH (NUM_CH),
        .PHASE_W(PHASE_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) bus ();

    sine_lut_scheduler #(
        .NUM_CH (NUM_CH),
        .PHASE_W(PHASE_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Registered ROM: data = {zeros, addr}, one cycle after the address.
    always @(posedge clk) begin
        bus.lut_data <= {{(DATA_W-ADDR_W){1'b0}}, bus.lut_addr};
    end

    // ---------------- scoreboard / reference model ----------------
    frame_t             sb_q[$];
    logic [PHASE_W-1:0] m_acc [NUM_CH];
    int                 m_left     = 0;   // busy cycles still to run
    bit                 m_pend     = 1'b0;
    bit                 m_ovr      = 1'b0;
    bit                 m_fv       = 1'b0;
    bit                 m_rst_edge = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input bit rst, input bit t, input bit s);
        frame_t f;
        m_rst_edge = rst;
        m_fv       = 1'b0;
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
            m_left = 0;
            m_pend = 1'b0;
            m_ovr  = 1'b0;
            sb_q.delete();
            return;
        end
        if (m_left == 0) begin
            if (s) begin
                for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
            end
            if (t) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (bus.ch_en[k]) begin
                        f.addr[k] = ADDR_W'(m_acc[k] >> (PHASE_W - ADDR_W));
                        f.samp[k] = DATA_W'(f.addr[k]);
                        m_acc[k]  = m_acc[k] + bus.freq_word[k*PHASE_W +: PHASE_W];
                    end else begin
                        f.addr[k] = '0;
                        f.samp[k] = '0;
                        m_acc[k]  = '0;
                    end
                end
                sb_q.push_back(f);
                m_left = NUM_CH + 1;
            end
        end else begin
            if (t) m_ovr = 1'b1;
            if (s) m_pend = 1'b1;
            m_left--;
            if (m_left == 0) begin
                m_fv = 1'b1;
                if (m_pend) begin
                    for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
                end
                m_pend = 1'b0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [NUM_CH-1:0][ADDR_W-1:0] rec;
    logic [NUM_CH*DATA_W-1:0]      hold = '0;
    int                            bidx = 0;

    always @(negedge clk) begin
        frame_t f;
        if (m_rst_edge) begin
            hold = '0;
            bidx = 0;
        end else begin
            check("busy", bus.busy, (m_left != 0));
            check("overrun", bus.overrun, m_ovr);
            check("frame_valid", bus.frame_valid, m_fv);
            if (bus.busy) begin
                if (bidx < NUM_CH) rec[bidx] = bus.lut_addr;
                bidx++;
            end else begin
                bidx = 0;
            end
            if (bus.frame_valid) begin
                check("sb_has_frame", (sb_q.size() != 0), 1'b1);
                if (sb_q.size() != 0) begin
                    f = sb_q.pop_front();
                    for (int k = 0; k < NUM_CH; k++) begin
                        check($sformatf("lut_addr_ch%0d", k), rec[k], f.addr[k]);
                    end
                    check("ch_sample_frame", bus.ch_sample, f.samp);
                    hold = f.samp;
                end
            end else if (!bus.busy) begin
                check("ch_sample_hold", bus.ch_sample, hold);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit t, input bit s);
        bus.sample_tick = t;
        bus.phase_sync  = s;
        @(posedge clk);
        model_edge(reset, t, s);
        @(negedge clk);
        bus.sample_tick = 1'b0;
        bus.phase_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic set_all_freq(input logic [PHASE_W-1:0] fw);
        for (int k = 0; k < NUM_CH; k++) bus.freq_word[k*PHASE_W +: PHASE_W] = fw;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        check("rst_lut_addr", bus.lut_addr, 0);
        check("rst_ch_sample", bus.ch_sample, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_valid", bus.frame_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [NUM_CH*DATA_W-1:0] exp_s;
        bus.sample_tick = 1'b0;
        bus.phase_sync  = 1'b0;
        bus.ch_en       = '1;
        bus.freq_word   = '0;
        for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
        step(1'b0, 1'b0);
        do_reset();

        // 1: equal step on all channels, three spaced frames -> addr 0,1,2
        set_all_freq(32'h0040_0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            idle(9);
        end
        check("t1_samples", bus.ch_sample, {NUM_CH{16'd2}});

        // 2: ch2 steps backwards through the wrap -> 0, 1023, 1022
        do_reset();
        set_all_freq(32'h0);
        bus.freq_word[2*PHASE_W +: PHASE_W] = 32'hFFC0_0000;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            idle(9);
        end
        check("t2_ch2", bus.ch_sample[2*DATA_W +: DATA_W], 16'd1022);
        check("t2_ch0", bus.ch_sample[0 +: DATA_W], 16'd0);

        // 3: tick in cycle 3 dropped (overrun), tick in cycle 6 accepted
        do_reset();
        set_all_freq(32'h0040_0000);
        step(1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0);
        idle(10);
        check("t3_overrun_sticky", bus.overrun, 1'b1);
        check("t3_samples", bus.ch_sample, {NUM_CH{16'd1}});

        // 4: ch2 disabled, others step by 4
        do_reset();
        bus.ch_en = 4'b1011;
        set_all_freq(32'h0100_0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            idle(7);
        end
        exp_s = {16'd8, 16'd0, 16'd8, 16'd8};
        check("t4_samples", bus.ch_sample, exp_s);

        // 5: phase_sync mid-frame is deferred; with tick in IDLE it applies first
        bus.ch_en = '1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        idle(7);
        step(1'b1, 1'b0);
        idle(7);
        check("t5_after_sync", bus.ch_sample, 0);
        step(1'b1, 1'b1);
        idle(7);
        check("t5_sync_tick", bus.ch_sample, 0);
        step(1'b1, 1'b0);
        idle(7);
        check("t5_restart", bus.ch_sample, {NUM_CH{16'd4}});

        // 6: reset in cycle 3 aborts the frame (overrun set first)
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        do_reset();
        idle(8);
        step(1'b1, 1'b0);
        idle(7);
        check("t6_fresh_frame", bus.ch_sample, 0);

        // Random traffic: config changes only between frames
        for (int i = 0; i < 600; i++) begin
            if (m_left == 0 && ($urandom % 4) == 0) begin
                bus.ch_en = NUM_CH'($urandom);
                for (int k = 0; k < NUM_CH; k++) begin
                    bus.freq_word[k*PHASE_W +: PHASE_W] =
                        (($urandom % 2) == 0) ? $urandom : ($urandom_range(0, 31) << (PHASE_W - ADDR_W));
                end
            end
            if (($urandom % 150) == 0) begin
                reset = 1'b1;
                step(1'b0, 1'b0);
                reset = 1'b0;
            end else begin
                step(($urandom % 3) == 0, ($urandom % 16) == 0);
            end
        end

        idle(12);
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
